// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: DIFF = A_in - B_in over WIDTH cycles with a start/done handshake.
// Optional SIGNED_OVF_EN macro adds an OVERFLOW output (two's-complement overflow of A-B).
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             START_in,
   input  logic [WIDTH-1:0] A_in,
   input  logic [WIDTH-1:0] B_in,
   output logic             BUSY,
`ifdef SIGNED_OVF_EN
   output logic             OVERFLOW,
`endif
   output logic             DONE,
   output logic [WIDTH-1:0] DIFF,
   output logic             BORROW
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t             state_reg;
   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic [WIDTH-1:0]   res_reg;
   logic               br_reg;
   logic [CNT_W-1:0]   cnt_reg;
`ifdef SIGNED_OVF_EN
   logic               a_msb_reg;
   logic               b_msb_reg;
`endif

   // Single reused full-subtractor slice.
   logic               bit_a;
   logic               bit_b;
   logic               d_next;
   logic               br_next;
   logic [WIDTH-1:0]   res_next;

   assign bit_a    = a_reg[0];
   assign bit_b    = b_reg[0];
   assign d_next   = bit_a ^ bit_b ^ br_reg;
   assign br_next  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_reg);
   assign res_next = {d_next, res_reg[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         res_reg   <= '0;
         br_reg    <= 1'b0;
         cnt_reg   <= '0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         DIFF      <= '0;
         BORROW    <= 1'b0;
`ifdef SIGNED_OVF_EN
         a_msb_reg <= 1'b0;
         b_msb_reg <= 1'b0;
         OVERFLOW  <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               DONE <= 1'b0;
               if (START_in) begin
                  a_reg     <= A_in;
                  b_reg     <= B_in;
                  res_reg   <= '0;
                  br_reg    <= 1'b0;
                  cnt_reg   <= '0;
                  BUSY      <= 1'b1;
                  state_reg <= RUN;
`ifdef SIGNED_OVF_EN
                  a_msb_reg <= A_in[WIDTH-1];
                  b_msb_reg <= B_in[WIDTH-1];
`endif
               end
            end
            RUN: begin
               res_reg <= res_next;
               a_reg   <= a_reg >> 1;
               b_reg   <= b_reg >> 1;
               br_reg  <= br_next;
               cnt_reg <= cnt_reg + 1'b1;
               // Results are published on entry to FIN so DONE and DIFF are valid together.
               if (cnt_reg == LAST_BIT) begin
                  DIFF      <= res_next;
                  BORROW    <= br_next;
                  DONE      <= 1'b1;
                  state_reg <= FIN;
`ifdef SIGNED_OVF_EN
                  OVERFLOW  <= (a_msb_reg != b_msb_reg) && (d_next != a_msb_reg);
`endif
               end
            end
            FIN: begin
               DONE      <= 1'b0;
               BUSY      <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               DONE      <= 1'b0;
               BUSY      <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, hand-written corner sequences
// and randomized operands checked against an arithmetic reference model.
module tb_serial_subtractor;

   localparam int W = 8;

   logic          clk;
   logic          rst_n;
   logic          start_in;
   logic [W-1:0]  a_in;
   logic [W-1:0]  b_in;
   logic          busy;
   logic          done;
   logic [W-1:0]  diff;
   logic          borrow;
`ifdef SIGNED_OVF_EN
   logic          overflow;
`endif

   int checks = 0;
   int errors = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .START_in (start_in),
      .A_in     (a_in),
      .B_in     (b_in),
      .BUSY     (busy),
`ifdef SIGNED_OVF_EN
      .OVERFLOW (overflow),
`endif
      .DONE     (done),
      .DIFF     (diff),
      .BORROW   (borrow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_diff;
      logic         exp_borrow;
      logic         exp_ovf;
   } vec_t;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: plain unsigned and signed integer arithmetic.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] ed, output logic eb, output logic eo);
      longint ua, ub, sa, sb, sr;
      ua = longint'(a);
      ub = longint'(b);
      ed = W'(ua - ub + (longint'(1) << W));
      eb = (ua < ub);
      sa = (ua >= (longint'(1) << (W - 1))) ? ua - (longint'(1) << W) : ua;
      sb = (ub >= (longint'(1) << (W - 1))) ? ub - (longint'(1) << W) : ub;
      sr = sa - sb;
      eo = (sr > ((longint'(1) << (W - 1)) - 1)) || (sr < -(longint'(1) << (W - 1)));
   endtask

   // One operation: START for one cycle, then per-cycle BUSY/DONE checks and result check.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ed, input logic eb, input logic eo,
                         input bit disturb, input string tag);
      @(negedge clk);
      start_in = 1'b1;
      a_in     = a;
      b_in     = b;
      @(posedge clk);
      for (int n = 0; n <= W + 1; n++) begin
         @(negedge clk);
         check({tag, " busy"}, 64'(busy), 64'(n <= W));
         check({tag, " done"}, 64'(done), 64'(n == W));
         if (n == W) begin
            check({tag, " diff"}, 64'(diff), 64'(ed));
            check({tag, " borrow"}, 64'(borrow), 64'(eb));
`ifdef SIGNED_OVF_EN
            check({tag, " overflow"}, 64'(overflow), 64'(eo));
`endif
         end
         if (n == 0) begin
            start_in = 1'b0;
            a_in     = W'($urandom);
            b_in     = W'($urandom);
         end
         if (disturb && n == 3) begin
            start_in = 1'b1;
            a_in     = W'(1);
            b_in     = W'(1);
         end
         if (disturb && n == 4) start_in = 1'b0;
      end
      $display("op %s: A=0x%0h B=0x%0h DIFF=0x%0h BORROW=%0d", tag, a, b, diff, borrow);
   endtask

   vec_t vecs [8];
   logic [W-1:0] ed;
   logic         eb;
   logic         eo;
   int           done_at [$];
   bit           stable;

   initial begin
      vecs[0] = '{a: 8'h5A, b: 8'h23, exp_diff: 8'h37, exp_borrow: 1'b0, exp_ovf: 1'b0};
      vecs[1] = '{a: 8'h10, b: 8'h20, exp_diff: 8'hF0, exp_borrow: 1'b1, exp_ovf: 1'b0};
      vecs[2] = '{a: 8'hFF, b: 8'hFF, exp_diff: 8'h00, exp_borrow: 1'b0, exp_ovf: 1'b0};
      vecs[3] = '{a: 8'h00, b: 8'h01, exp_diff: 8'hFF, exp_borrow: 1'b1, exp_ovf: 1'b0};
      vecs[4] = '{a: 8'h80, b: 8'h01, exp_diff: 8'h7F, exp_borrow: 1'b0, exp_ovf: 1'b1};
      vecs[5] = '{a: 8'h05, b: 8'h03, exp_diff: 8'h02, exp_borrow: 1'b0, exp_ovf: 1'b0};
      vecs[6] = '{a: 8'h7F, b: 8'hFF, exp_diff: 8'h80, exp_borrow: 1'b1, exp_ovf: 1'b1};
      vecs[7] = '{a: 8'h00, b: 8'h80, exp_diff: 8'h80, exp_borrow: 1'b1, exp_ovf: 1'b1};

      rst_n    = 1'b0;
      start_in = 1'b0;
      a_in     = '0;
      b_in     = '0;
      repeat (3) @(negedge clk);
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset diff", 64'(diff), 64'd0);
      check("reset borrow", 64'(borrow), 64'd0);
      rst_n = 1'b1;

      // Table vectors.
      for (int i = 0; i < 8; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].exp_diff, vecs[i].exp_borrow, vecs[i].exp_ovf,
                1'b0, $sformatf("vec%0d", i));

      // Result holds while idle.
      run_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b0, "hold");
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (diff !== 8'hF0 || borrow !== 1'b1 || done !== 1'b0) stable = 1'b0;
      end
      check("hold stable", 64'(stable), 64'd1);
      $display("hold: DIFF=0x%0h BORROW=%0d after 20 idle cycles", diff, borrow);

      // START and operands disturbed mid-run must not affect the result.
      run_op(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, 1'b1, "ignore");

      // Back-to-back with START held high.
      @(negedge clk);
      start_in = 1'b1;
      a_in     = 8'hFF;
      b_in     = 8'hFF;
      @(posedge clk);
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (n == 0) begin
            a_in = 8'h00;
            b_in = 8'h01;
         end
         if (done) begin
            done_at.push_back(n);
            if (done_at.size() == 1) begin
               check("b2b first diff", 64'(diff), 64'h00);
               check("b2b first borrow", 64'(borrow), 64'd0);
            end else if (done_at.size() == 2) begin
               check("b2b second diff", 64'(diff), 64'hFF);
               check("b2b second borrow", 64'(borrow), 64'd1);
               start_in = 1'b0;
            end
         end
      end
      start_in = 1'b0;
      check("b2b done count", 64'(done_at.size()), 64'd2);
      if (done_at.size() == 2) begin
         check("b2b first at", 64'(done_at[0]), 64'(W));
         check("b2b spacing", 64'(done_at[1] - done_at[0]), 64'(W + 2));
      end
      $display("b2b: %0d DONE pulses", done_at.size());
      repeat (12) @(negedge clk);

      // Asynchronous reset mid-run.
      start_in = 1'b1;
      a_in     = 8'h12;
      b_in     = 8'h34;
      @(posedge clk);
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         start_in = 1'b0;
      end
      check("abort busy before", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("abort busy", 64'(busy), 64'd0);
      check("abort done", 64'(done), 64'd0);
      check("abort diff", 64'(diff), 64'd0);
      check("abort borrow", 64'(borrow), 64'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      stable = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) stable = 1'b0;
      end
      check("abort no done", 64'(stable), 64'd1);
      $display("abort: reset mid-run, no DONE afterwards");
      run_op(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, 1'b0, "after_abort");

      // Randomized operands against the model.
      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] ra, rb;
         ra = W'($urandom);
         rb = W'($urandom);
         if (i == 0) rb = ra;
         model(ra, rb, ed, eb, eo);
         run_op(ra, rb, ed, eb, eo, (i % 5) == 0, $sformatf("rand%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, checks %0d", checks);
      $fatal(1, "timeout");
   end

endmodule
